// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
// FSM state encoding, parity modes, sample phases and the divisor floor.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [3:0] PH_SAMPLE_A = 4'd7;
    localparam logic [3:0] PH_SAMPLE_B = 4'd8;
    localparam logic [3:0] PH_DECIDE   = 4'd9;
    localparam logic [3:0] PH_LAST     = 4'd15;

    localparam logic [15:0] MIN_DIV = 16'd2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small first-word-fall-through FIFO; the head is visible while not empty.
// A push into a full FIFO is taken only when a pop frees a slot in the same cycle.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Zero when empty so the consumer side shows clean values out of reset.
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with majority voting, break detect and output FIFO.
// Optional parity support is built when UART_RX_PARITY_EN is defined.
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [15:0]          cfg_div,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_perr,
    output logic                 m_ferr,
    output logic                 m_brk,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overrun,
    input  logic                 clr_overrun,
    output logic                 busy
);

    localparam int unsigned          clk_freq_unused = CLK_FREQ;
    localparam int                   BW       = $clog2(DATA_BITS);
    localparam logic [BW-1:0]        LAST_BIT = BW'(DATA_BITS - 1);
    localparam int                   EW       = DATA_BITS + 3;

    if (OVERSAMPLE != 16) begin : g_bad_oversample
        $error("uart_rx_ovs: OVERSAMPLE must be 16");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_ovs: DATA_BITS must be 5..9");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_ovs: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    rx_state_t            state;
    rx_state_t            state_n;
    logic                 rx_meta;
    logic                 rx_s;
    logic [15:0]          div_q;
    logic [15:0]          div_cnt;
    logic [3:0]           ph;
    logic                 samp_a;
    logic                 samp_b;
    logic                 tick;
    logic                 maj;
    logic                 start_go;
    logic                 at_decide;
    logic                 at_last;
    logic                 stop2_q;
    logic                 stop_idx;
    logic                 ferr_acc;
    logic [DATA_BITS-1:0] data_sr;
    logic [BW-1:0]        bit_cnt;
    logic                 push;
    logic                 push_brk;
    logic                 push_ferr;
    logic                 push_perr;
    logic [DATA_BITS-1:0] push_data;
    logic                 calc_perr;
    logic                 brk_par_ok;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [EW-1:0]        fifo_rdata;

`ifdef UART_RX_PARITY_EN
    logic par_en_q;
    logic par_odd_q;
    logic par_bit;

    assign calc_perr  = par_en_q && (par_bit != ((^data_sr) ^ par_odd_q));
    assign brk_par_ok = !(par_en_q && par_bit);
`else
    logic unused_cfg_parity;

    assign unused_cfg_parity = ^cfg_parity;
    assign calc_perr         = 1'b0;
    assign brk_par_ok        = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign start_go  = (state == ST_IDLE) && !rx_s;
    assign tick      = (state != ST_IDLE) && (div_cnt == div_q - 16'd1);
    assign at_decide = tick && (ph == PH_DECIDE);
    assign at_last   = tick && (ph == PH_LAST);
    assign maj       = maj3(samp_a, samp_b, rx_s);

    // Counters sit at zero in IDLE so every frame starts phase-aligned to its start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            ph      <= '0;
            samp_a  <= 1'b1;
            samp_b  <= 1'b1;
        end else if (state == ST_IDLE) begin
            div_cnt <= '0;
            ph      <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            ph      <= ph + 4'd1;
            if (ph == PH_SAMPLE_A) samp_a <= rx_s;
            if (ph == PH_SAMPLE_B) samp_b <= rx_s;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= MIN_DIV;
            stop2_q  <= 1'b0;
            stop_idx <= 1'b0;
            ferr_acc <= 1'b0;
            data_sr  <= '0;
            bit_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_bit   <= 1'b0;
`endif
        end else if (start_go) begin
            div_q    <= (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
            stop2_q  <= cfg_stop2;
            stop_idx <= 1'b0;
            ferr_acc <= 1'b0;
            data_sr  <= '0;
            bit_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
            par_en_q  <= (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
            par_odd_q <= (cfg_parity == PAR_ODD);
            par_bit   <= 1'b0;
`endif
        end else begin
            if (state == ST_DATA && at_decide) data_sr <= {maj, data_sr[DATA_BITS-1:1]};
            if (state == ST_DATA && at_last)   bit_cnt <= bit_cnt + BW'(1);
`ifdef UART_RX_PARITY_EN
            if (state == ST_PARITY && at_decide) par_bit <= maj;
`endif
            if (state == ST_STOP && at_decide) ferr_acc <= ferr_acc | !maj;
            if (state == ST_STOP && at_last)   stop_idx <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // The word is pushed at the last stop-bit decision, leaving half a bit to resync on the next start.
    always_comb begin
        state_n   = state;
        push      = 1'b0;
        push_brk  = 1'b0;
        push_ferr = 1'b0;
        push_perr = 1'b0;
        push_data = data_sr;
        case (state)
            ST_IDLE: begin
                if (!rx_s) state_n = ST_START;
            end
            ST_START: begin
                if (at_decide && maj) state_n = ST_IDLE;
                else if (at_last)     state_n = ST_DATA;
            end
            ST_DATA: begin
                if (at_last && bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                    state_n = par_en_q ? ST_PARITY : ST_STOP;
`else
                    state_n = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (at_last) state_n = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (at_decide) begin
                    if (!stop_idx && !maj && data_sr == '0 && brk_par_ok) begin
                        push      = 1'b1;
                        push_brk  = 1'b1;
                        push_ferr = 1'b1;
                        push_data = '0;
                        state_n   = ST_BRK_WAIT;
                    end else if (stop_idx || !stop2_q) begin
                        push      = 1'b1;
                        push_ferr = ferr_acc | !maj;
                        push_perr = calc_perr;
                        state_n   = ST_IDLE;
                    end
                end
            end
            ST_BRK_WAIT: begin
                if (rx_s) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign pop = m_valid && m_ready;

    uart_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({push_brk, push_ferr, push_perr, push_data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m_valid                        = !fifo_empty;
    assign {m_brk, m_ferr, m_perr, m_data} = fifo_rdata;
    assign busy                           = (state != ST_IDLE);

    // A dropped word outranks a clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)                                 overrun <= 1'b0;
        else if (push && fifo_full && !pop)      overrun <= 1'b1;
        else if (clr_overrun)                    overrun <= 1'b0;
    end

endmodule
